// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle CPU sequencing controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2     = 2'd0;
    localparam logic [1:0] SRCB_IMM     = 2'd1;
    localparam logic [1:0] SRCB_FOUR    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] PCSEL_ALU    = 2'd0;
    localparam logic [1:0] PCSEL_ALUOUT = 2'd1;
    localparam logic [1:0] PCSEL_JALR   = 2'd2;

endpackage

// File: rtl/branch_resolve.sv
// Branch condition decode: maps funct3 and comparator flags to taken/legal.
module branch_resolve
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    output logic       taken,
    output logic       legal
);

    // funct3 decode of the supported conditional branches
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  taken = br_eq;
            F3_BNE:  taken = !br_eq;
            F3_BLT:  taken = br_lt;
            F3_BGE:  taken = !br_lt;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: steps fetch/decode/execute/memory/write-back over a
// shared ALU and memory port, drives datapath controls and counts retirements.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [3:0]  state_o
);

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        taken_s, legal_s, retire_s;
    logic        unused_s;

    // funct7 is decoded by the ALU control, not by the sequencer
    assign unused_s = funct7b5;

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .br_eq  (BrEq),
        .br_lt  (BrLT),
        .taken  (taken_s),
        .legal  (legal_s)
    );

    // next-state, control decode and retire counting
    always_comb begin
        state_d    = state_q;
        retire_s   = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        mem_to_reg = M2R_ALUOUT;
        pc_sel     = PCSEL_ALU;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM_SH1;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_JALR:            state_d = S_JALR;
                    default:            state_d = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_LOAD) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEM_WR;
                end
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_SUB;
                pc_sel    = PCSEL_ALUOUT;
                if (legal_s) begin
                    pc_write = taken_s;
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_HALT;
                end
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_sel     = PCSEL_ALUOUT;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                pc_sel     = PCSEL_JALR;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        instret_d = instret_q + {31'd0, retire_s};
        // reset masks every control combinationally, including the Mealy strobes
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            mem_to_reg = 2'd0;
            pc_sel     = RESET_PC_SEL;
            illegal    = 1'b0;
        end else begin
            illegal    = (state_q == S_HALT);
        end
    end

    // state and retire counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction state sequences and
// control tables derived from the instruction class, with randomized waits.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic        clk, rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5, br_eq, br_lt, mem_ready;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_sel;
    logic [31:0] instret;
    logic [3:0]  state_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_instret = 32'd0;

    multicycle_ctrl #(.RESET_PC_SEL(2'd0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .BrEq(br_eq), .BrLT(br_lt), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .pc_sel(pc_sel), .illegal(illegal),
        .instret(instret), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Control row for each state: {mask, expected} over
    // {pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, a, b, op, m2r, pc_sel}
    function automatic logic [31:0] spec_row(input state_e s, input logic mr, input logic tk);
        logic [15:0] e, m;
        e = 16'd0;
        m = 16'hF800;
        case (s)
            S_FETCH:    begin e[12] = 1'b1; e[15] = mr; e[14] = mr; e[7:6] = 2'd2; m = m | 16'h07F3; end
            S_DECODE:   begin e[9:8] = 2'd1; e[7:6] = 2'd3; m = m | 16'h03F0; end
            S_EXEC_R:   begin e[9:8] = 2'd2; e[5:4] = 2'd2; m = m | 16'h03F0; end
            S_EXEC_I:   begin e[9:8] = 2'd2; e[7:6] = 2'd1; e[5:4] = 2'd2; m = m | 16'h03F0; end
            S_WB_ALU:   begin e[13] = 1'b1; m = m | 16'h000C; end
            S_MEM_ADDR: begin e[9:8] = 2'd2; e[7:6] = 2'd1; m = m | 16'h03F0; end
            S_MEM_RD:   begin e[12] = 1'b1; e[10] = 1'b1; m = m | 16'h0400; end
            S_MEM_WB:   begin e[13] = 1'b1; e[3:2] = 2'd1; m = m | 16'h000C; end
            S_MEM_WR:   begin e[11] = 1'b1; e[10] = 1'b1; m = m | 16'h0400; end
            S_BRANCH:   begin e[15] = tk; e[9:8] = 2'd2; e[5:4] = 2'd1; e[1:0] = 2'd1; m = m | 16'h03F3; end
            S_JAL:      begin e[15] = 1'b1; e[13] = 1'b1; e[3:2] = 2'd2; e[1:0] = 2'd1; m = m | 16'h000F; end
            S_JALR:     begin e[15] = 1'b1; e[13] = 1'b1; e[9:8] = 2'd2; e[7:6] = 2'd1;
                              e[3:2] = 2'd2; e[1:0] = 2'd2; m = m | 16'h03FF; end
            default:    m = 16'hF800;
        endcase
        return {m, e};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_instret = 32'd0;
    endtask

    // Runs one instruction from FETCH; wf/wm are wait cycles on fetch / data access.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic beq,
                             input logic blt, input int wf, input int wm);
        state_e      exp_q[$];
        logic        tk, lg, halts, bad;
        int          fc, mc;
        logic [15:0] got, e, m;
        logic [31:0] row;
        lg = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
        tk = (f3 == 3'd0) ? beq : (f3 == 3'd1) ? !beq : (f3 == 3'd4) ? blt :
             (f3 == 3'd5) ? !blt : 1'b0;
        halts = 1'b0;
        for (int i = 0; i <= wf; i++) exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        case (op)
            7'b0110011: begin exp_q.push_back(S_EXEC_R); exp_q.push_back(S_WB_ALU); end
            7'b0010011: begin exp_q.push_back(S_EXEC_I); exp_q.push_back(S_WB_ALU); end
            7'b0000011: begin
                exp_q.push_back(S_MEM_ADDR);
                for (int i = 0; i <= wm; i++) exp_q.push_back(S_MEM_RD);
                exp_q.push_back(S_MEM_WB);
            end
            7'b0100011: begin
                exp_q.push_back(S_MEM_ADDR);
                for (int i = 0; i <= wm; i++) exp_q.push_back(S_MEM_WR);
            end
            7'b1100011: begin exp_q.push_back(S_BRANCH); halts = !lg; end
            7'b1101111: exp_q.push_back(S_JAL);
            7'b1100111: exp_q.push_back(S_JALR);
            default:    halts = 1'b1;
        endcase
        opcode = op; funct3 = f3; funct7b5 = 1'($urandom_range(1, 0));
        br_eq = beq; br_lt = blt;
        fc = wf; mc = wm; bad = 1'b0;
        foreach (exp_q[c]) begin
            @(negedge clk);
            if (state_o == S_FETCH) begin
                mem_ready = (fc == 0);
                if (fc > 0) fc--;
            end else if (state_o == S_MEM_RD || state_o == S_MEM_WR) begin
                mem_ready = (mc == 0);
                if (mc > 0) mc--;
            end else begin
                mem_ready = 1'($urandom_range(1, 0));
            end
            #1;
            n_cmp++;
            if (state_o !== exp_q[c]) begin
                n_err++;
                $display("FAIL state_seq op=%b step=%0d: got %0d expected %0d", op, c, state_o, exp_q[c]);
                bad = 1'b1;
                break;
            end
            row = spec_row(exp_q[c], mem_ready, tk && lg);
            m = row[31:16];
            e = row[15:0];
            got = {pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
                   alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_sel};
            n_cmp++;
            if ((got & m) !== (e & m)) begin
                n_err++;
                $display("FAIL controls op=%b state=%0d: got %04h expected %04h (mask %04h)",
                         op, state_o, got & m, e & m, m);
            end
            n_cmp++;
            if (illegal !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_early op=%b: got %b expected 0", op, illegal);
            end
        end
        if (bad) begin
            do_reset();
        end else begin
            @(posedge clk);
            #1;
            if (!halts) model_instret = model_instret + 32'd1;
            n_cmp++;
            if (state_o !== (halts ? S_HALT : S_FETCH)) begin
                n_err++;
                $display("FAIL end_state op=%b: got %0d expected %0d", op, state_o,
                         halts ? S_HALT : S_FETCH);
            end
            n_cmp++;
            if (instret !== model_instret) begin
                n_err++;
                $display("FAIL instret op=%b: got %0h expected %0h", op, instret, model_instret);
            end
            n_cmp++;
            if (illegal !== halts) begin
                n_err++;
                $display("FAIL illegal_end op=%b: got %b expected %b", op, illegal, halts);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({pc_write, ir_write, reg_write, mem_read, mem_write, illegal} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_enables: got %b expected 000000",
                     {pc_write, ir_write, reg_write, mem_read, mem_write, illegal});
        end
        n_cmp++;
        if ({i_or_d, alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_sel} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_selects: got %h expected 0",
                     {i_or_d, alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_sel});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== S_FETCH || instret !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: got state %0d instret %0h expected 0 / 0", state_o, instret);
        end
        model_instret = 32'd0;
    endtask

    task automatic test_add();
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_load_wait();
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3);
    endtask

    task automatic test_bne();
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1100011, 3'd1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        logic [2:0] f3s [4];
        logic [6:0] op;
        logic [2:0] f3;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b1100011};
        f3s = '{3'd0, 3'd1, 3'd4, 3'd5};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(7, 0)];
            f3 = (op == 7'b1100011) ? f3s[$urandom_range(3, 0)] : 3'($urandom_range(7, 0));
            run_instr(op, f3, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_reset_in_store_wait();
        opcode = 7'b0100011;
        funct3 = 3'd2;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (state_o !== S_MEM_WR || mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL store_wait: got state %0d mem_write %b expected %0d / 1",
                     state_o, mem_write, S_MEM_WR);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ir_write, reg_write, mem_read, mem_write} !== 5'd0) begin
            n_err++;
            $display("FAIL store_reset_strobe: got %b expected 00000",
                     {pc_write, ir_write, reg_write, mem_read, mem_write});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_o !== S_FETCH || instret !== 32'd0) begin
            n_err++;
            $display("FAIL store_reset_state: got state %0d instret %0h expected 0 / 0",
                     state_o, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        model_instret = 32'd0;
    endtask

    task automatic test_instret_wrap();
        @(negedge clk);
        mem_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        #1;
        n_cmp++;
        if (instret !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preload: got %0h expected ffffffff", instret);
        end
        model_instret = 32'hFFFF_FFFF;
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_illegal_branch();
        run_instr(7'b1100011, 3'd2, 1'b1, 1'b1, 1, 0);
        do_reset();
    endtask

    task automatic test_halt();
        run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(1, 0));
            #1;
            n_cmp++;
            if ({state_o, illegal, pc_write, ir_write, reg_write, mem_read, mem_write} !==
                {S_HALT, 1'b1, 5'd0}) begin
                n_err++;
                $display("FAIL halt_hold cycle %0d: got state %0d illegal %b enables %b",
                         i, state_o, illegal, {pc_write, ir_write, reg_write, mem_read, mem_write});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_err++;
            $display("FAIL halt_rst_illegal: got %b expected 0", illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== S_FETCH || illegal !== 1'b0 || instret !== 32'd0) begin
            n_err++;
            $display("FAIL halt_recover: got state %0d illegal %b instret %0h expected 0 / 0 / 0",
                     state_o, illegal, instret);
        end
        model_instret = 32'd0;
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        br_eq = 1'b0; br_lt = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_load_wait();
        test_bne();
        test_random();
        test_reset_in_store_wait();
        test_instret_wrap();
        test_illegal_branch();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle build of the CPU. It replaces the single-cycle decoder with a state machine that time-shares one ALU and one unified memory port across fetch, decode, execute, memory and write-back steps. It consumes the instruction register fields, the branch comparator flags and a memory ready handshake. It drives every datapath enable and mux select, and it counts retired instructions.

## Interface
- `RESET_PC_SEL`, default 0: `pc_sel` value held during reset.
- `clk`  in  1  clock. All state updates occur on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `opcode`  in  7  instruction register [6:0].
- `funct3`  in  3  instruction register [14:12].
- `funct7b5`  in  1  instruction register [30].
- `BrEq`, `BrLT`  in  1 each  branch comparator flags.
- `mem_ready`  in  1  memory completed the current read or write this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  datapath enables.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `alu_src_a`  out  2  ALU A select: 0 = PC, 1 = old_pc, 2 = rs1.
- `alu_src_b`  out  2  ALU B select: 0 = rs2, 1 = imm, 2 = const 4, 3 = imm<<1.
- `alu_op`  out  2  ALU operation: 0 = add, 1 = sub/compare, 2 = funct-decoded.
- `mem_to_reg`  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC.
- `pc_sel`  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1.
- `illegal`  out  1  sticky flag for an illegal instruction.
- `instret`  out  32  count of retired instructions.
- `state_o`  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, HALT.
- FETCH:
  - Drives `mem_read=1`, `i_or_d=0`, `alu_src_a=0`, `alu_src_b=2`, `alu_op=0`, `pc_sel=0`.
  - `ir_write` and `pc_write` follow `mem_ready` (Mealy).
  - Stays in FETCH until `mem_ready`, then moves to DECODE.
- DECODE:
  - Drives `alu_src_a=1`, `alu_src_b=3`, `alu_op=0`, so the branch target lands in ALUOut.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 and 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - any other opcode → HALT
- EXEC_R: `alu_src_a=2`, `alu_src_b=0`, `alu_op=2`, then WB_ALU.
- EXEC_I: `alu_src_a=2`, `alu_src_b=1`, `alu_op=2`, then WB_ALU.
- WB_ALU: `reg_write=1`, `mem_to_reg=0`, retire, then FETCH.
- MEM_ADDR: `alu_src_a=2`, `alu_src_b=1`, `alu_op=0`. Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD:
  - Drives `mem_read=1`, `i_or_d=1`.
  - Waits for `mem_ready`, then moves to MEM_WB.
- MEM_WB: `reg_write=1`, `mem_to_reg=1`, retire, then FETCH.
- MEM_WR:
  - Drives `mem_write=1`, `i_or_d=1`.
  - Waits for `mem_ready`, then retires and moves to FETCH.
- BRANCH:
  - Drives `alu_src_a=2`, `alu_src_b=0`, `alu_op=1`, `pc_sel=1`.
  - `pc_write` equals `taken`, where:
    - `taken` is `BrEq` for funct3=000 and `!BrEq` for 001.
    - `taken` is `BrLT` for 100 and `!BrLT` for 101.
  - Any other funct3 → HALT with no write.
  - Otherwise retire, then FETCH.
- JAL:
  - `pc_write=1`, `pc_sel=1`, `reg_write=1`, `mem_to_reg=2`. The PC value written back is already PC+4.
  - Retire, then FETCH.
- JALR:
  - `alu_src_a=2`, `alu_src_b=1`, `alu_op=0`, `pc_sel=2`, `pc_write=1`, `reg_write=1`, `mem_to_reg=2`.
  - Retire, then FETCH.
- HALT:
  - `illegal=1`. All enables are 0.
  - HALT is left only by reset.
- Retire: `instret` increments by 1 at the end of the retiring state and wraps from 0xFFFFFFFF to 0.
- Register writes to x0 are the register file's concern; this block does not filter them.

## Timing
- While `rst=1`:
  - All enables are forced to 0 combinationally.
  - `pc_sel` = RESET_PC_SEL; all other selects are 0.
  - `illegal=0`.
- The reset edge loads state = FETCH and `instret` = 0.
- Reset asserted mid-wait (MEM_RD/MEM_WR/FETCH) abandons the access. There is no write-back and no retire.
- Minimum cycles with `mem_ready` tied high:
  - R-type and I-type: 4
  - load: 5
  - store: 4
  - branch, jal, jalr: 3
- Each cycle with `mem_ready=0` adds one cycle. All enables other than the memory strobe are held 0 during wait cycles.
- `mem_read` and `mem_write` are never both 1.
- `pc_write` pulses at most once per instruction outside FETCH.

## Structure
- `mc_pkg` holds:
  - the state enum
  - opcode localparams
  - `alu_op`, `alu_src_a`/`alu_src_b`, `mem_to_reg`, `pc_sel` encodings
- Sub-module `branch_resolve` (combinational): funct3, `BrEq`, `BrLT` → `taken`, `legal`.
- Top level: state register, next-state logic, output decode, `instret` counter.

## Test plan
- `mem_ready` tied 1, `add x3,x1,x2` → state sequence FETCH, DECODE, EXEC_R, WB_ALU; `reg_write` high only in WB_ALU; `instret` 0→1 after 4 cycles.
- `lw` with `mem_ready` low for 3 cycles in MEM_RD → 8 total cycles; `mem_read`/`i_or_d=1` held throughout the wait; `reg_write` only in MEM_WB.
- `bne` with `BrEq=0` → `pc_write=1`, `pc_sel=1` in BRANCH; repeat with `BrEq=1` → `pc_write=0`; both retire in 3 cycles.
- opcode 0x7F → HALT after DECODE; `illegal=1`; no enables for 10 cycles; `rst` pulse → FETCH with `illegal=0`.
- `rst` asserted during a MEM_WR wait → next cycle is FETCH; `mem_write` dropped; `instret` = 0.
- Preload `instret` = 0xFFFFFFFF via a forced path, then `jal` → `instret` wraps to 0; `mem_to_reg=2` and `reg_write=1` in the JAL state.
